svm_linear_mc: RTL and testbench
================================

SVM_LINEAR_MC -- requirements
Module: svm_linear_mc

Interface
REQ-001 Parameters (name, default, meaning):
- NBITS, 9, signed width of one feature or weight.
- F_WIDTH, 214, features per vector.
- N_CLS, 4, number of linear decision functions.
- NPAR, 2, features multiplied per cycle; F_WIDTH % NPAR == 0.
- ACC_W, 2*NBITS+ceilLog2(F_WIDTH)+1, signed accumulator and bias width.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-low.
- mem_we  in  1  weight write strobe, active-low.
- mem_write_addr  in  ceilLog2(N_CLS*F_WIDTH/NPAR)  weight row address = c*(F_WIDTH/NPAR)+k.
- mem_wdata  in  NPAR*NBITS  NPAR signed weights; lane j = feature k*NPAR+j.
- bias_we  in  1  bias write strobe, active-high.
- bias_cls  in  ceilLog2(N_CLS)  class index for bias write.
- bias_data  in  ACC_W  signed bias.
- mem_write_done  in  1  one-cycle pulse ending the load phase.
- cfg_reload  in  1  request return to the load phase.
- mem_write_ready  out  1  load phase active.
- in_features  in  NBITS*F_WIDTH  feature f at [f*NBITS +: NBITS].
- fin_valid  in  1  feature vector valid.
- fin_ready  out  1  core can accept a vector.
- dout_label  out  N_CLS  bit c = (score_c >= 0).
- dout_class  out  ceilLog2(N_CLS)  argmax class.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts result.

Function
REQ-003 FSM states are LOAD, IDLE, COMPUTE and OUTPUT; the state after reset is LOAD.
REQ-004 LOAD: mem_write_ready=1 and fin_ready=0.
- A weight is written on any edge with mem_we==0.
- A bias is written on any edge with bias_we==1.
- A weight write and a bias write in the same cycle are both performed.
REQ-005 A weight write with mem_write_addr >= N_CLS*F_WIDTH/NPAR, or a bias write with bias_cls >= N_CLS, SHALL be ignored.
REQ-006 mem_write_done in LOAD moves the FSM to IDLE on that edge; a write in the same cycle still completes.
REQ-007 Writes outside LOAD SHALL be ignored.
REQ-008 IDLE: fin_ready=1.
- fin_valid&&fin_ready captures in_features into a local register and enters COMPUTE.
- cfg_reload in IDLE, with fin_valid low, enters LOAD; if both are high, the handshake wins.
REQ-009 COMPUTE runs K = N_CLS*F_WIDTH/NPAR cycles, class-major.
- Each cycle adds NPAR signed NBITS x NBITS products into the accumulator.
- The accumulator initialises to sign-extended bias[c] at the start of each class.
REQ-010 At each class end, score_c is reduced into label bit c and a running max; a tie keeps the lower class index.
REQ-011 Arithmetic is full-precision two's complement in ACC_W bits; no saturation or overflow is possible.
REQ-012 Latency: dout_valid rises exactly K+1 edges after the accepting edge (429 at defaults).
REQ-013 OUTPUT: dout_valid=1 with dout_label and dout_class held stable until dout_valid&&dout_ready; fin_ready=0.
- On that handshake edge the FSM returns to IDLE and dout_valid drops.
REQ-014 fin_valid and in_features changes during COMPUTE or OUTPUT SHALL NOT affect the result in flight.

Reset
REQ-015 rst low asynchronously forces:
- state LOAD;
- mem_write_ready=1 (the only output at 1);
- fin_ready=0, dout_valid=0, dout_label=0, dout_class=0;
- accumulator and internal counters 0.
REQ-016 Weight and bias storage SHALL NOT be reset; contents are retained across rst and cfg_reload, and leaving LOAD needs only mem_write_done.
REQ-017 Reset mid-COMPUTE or mid-OUTPUT discards the result in flight; no dout_valid is produced for it.

Verification
REQ-018 Weights all 0, biases {5,-3,0,-1}, any vector -> after 429 cycles dout_label=4'b0101, dout_class=0.
REQ-019 Weights 0, biases {7,7,-1,-1} -> dout_class=0 (tie resolves to lower index), dout_label=4'b0011.
REQ-020 All features -256, class-3 weights all -256, other weights and all biases 0 -> score_3=14024704, dout_label=4'b1111, dout_class=3.
REQ-021 dout_ready=0 for 10 cycles after dout_valid -> outputs stable, fin_ready=0; result consumed on the first dout_ready=1 edge, then fin_ready=1 next cycle.
REQ-022 rst asserted 100 cycles into COMPUTE, then mem_write_done with no writes -> same vector reproduces the pre-reset result, confirming weights retained.
REQ-023 Out-of-range mem_write_addr and bias_cls writes, and writes during IDLE -> stored weights unchanged (checked via REQ-018 result).

Source files
------------

// File: rtl/svm_linear_mc.sv
// Multi-class linear SVM: per-class dot product of a feature vector with stored
// weights plus bias, NPAR MACs per cycle, with sign labels and argmax class.
module svm_linear_mc #(
  parameter int NBITS   = 9,
  parameter int F_WIDTH = 214,
  parameter int N_CLS   = 4,
  parameter int NPAR    = 2,
  parameter int ACC_W   = 2*NBITS + $clog2(F_WIDTH) + 1,
  localparam int K      = N_CLS*F_WIDTH/NPAR,
  localparam int AW     = (K > 1) ? $clog2(K) : 1,
  localparam int CW     = (N_CLS > 1) ? $clog2(N_CLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_we,
  input  logic [AW-1:0]            mem_write_addr,
  input  logic [NPAR*NBITS-1:0]    mem_wdata,
  input  logic                     bias_we,
  input  logic [CW-1:0]            bias_cls,
  input  logic [ACC_W-1:0]         bias_data,
  input  logic                     mem_write_done,
  input  logic                     cfg_reload,
  output logic                     mem_write_ready,
  input  logic [NBITS*F_WIDTH-1:0] in_features,
  input  logic                     fin_valid,
  output logic                     fin_ready,
  output logic [N_CLS-1:0]         dout_label,
  output logic [CW-1:0]            dout_class,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int KPC = F_WIDTH/NPAR;
  localparam int KW  = (KPC > 1) ? $clog2(KPC) : 1;
  localparam int LW  = NPAR*NBITS;
  localparam int FW  = NBITS*F_WIDTH;
  localparam logic [AW:0]   K_LIM  = (AW+1)'(K);
  localparam logic [CW:0]   C_LIM  = (CW+1)'(N_CLS);
  localparam logic [KW-1:0] K_LAST = KW'(KPC-1);
  localparam logic [CW-1:0] C_LAST = CW'(N_CLS-1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_COMPUTE, S_OUTPUT} state_t;

  state_t state, state_nx;

  logic [LW-1:0]            w_mem [K];
  logic signed [ACC_W-1:0]  b_mem [N_CLS];
  logic [LW-1:0]            w_q;
  logic [FW-1:0]            feat_sr;
  logic [LW-1:0]            feat_q;
  logic [AW-1:0]            rd_addr;
  logic [KW-1:0]            k_cnt, p_k;
  logic [CW-1:0]            c_cnt, p_cls;
  logic                     issuing, p_valid;
  logic signed [ACC_W-1:0]  acc, acc_next, mac_sum, best;
  logic signed [NBITS-1:0]  fa, wb;
  logic signed [2*NBITS-1:0] prod;
  logic [N_CLS-1:0]         label_r;
  logic [CW-1:0]            best_cls;
  logic                     w_wr, b_wr, accept, last_mac;

  assign w_wr     = (state == S_LOAD) && !mem_we && ({1'b0, mem_write_addr} < K_LIM);
  assign b_wr     = (state == S_LOAD) && bias_we && ({1'b0, bias_cls} < C_LIM);
  assign accept   = (state == S_IDLE) && fin_valid;
  assign last_mac = p_valid && (p_cls == C_LAST) && (p_k == K_LAST);

  // NOTE: storage arrays carry no reset so they map onto RAM and survive rst.
  always_ff @(posedge clk) begin
    if (w_wr) w_mem[mem_write_addr] <= mem_wdata;
    w_q <= w_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (b_wr) b_mem[bias_cls] <= bias_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD:    if (mem_write_done) state_nx = S_IDLE;
      S_IDLE:    if (fin_valid) state_nx = S_COMPUTE;
                 else if (cfg_reload) state_nx = S_LOAD;
      S_COMPUTE: if (last_mac) state_nx = S_OUTPUT;
      S_OUTPUT:  if (dout_ready) state_nx = S_IDLE;
      default:   state_nx = S_LOAD;
    endcase
  end

  always_comb begin
    mem_write_ready = (state == S_LOAD);
    fin_ready       = (state == S_IDLE);
    dout_valid      = (state == S_OUTPUT);
  end

  // Sum of NPAR lane products, seeded with the class bias on the first row.
  always_comb begin
    mac_sum = '0;
    fa      = '0;
    wb      = '0;
    prod    = '0;
    for (int j = 0; j < NPAR; j++) begin
      fa      = feat_q[j*NBITS +: NBITS];
      wb      = w_q[j*NBITS +: NBITS];
      prod    = fa * wb;
      mac_sum = mac_sum + ACC_W'(prod);
    end
    acc_next = ((p_k == '0) ? b_mem[p_cls] : acc) + mac_sum;
  end

  // Issue stage walks rows class-major; the feature register rotates so lane
  // pair k is always at the bottom and wraps back after each class.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      feat_sr  <= '0;
      feat_q   <= '0;
      rd_addr  <= '0;
      k_cnt    <= '0;
      c_cnt    <= '0;
      issuing  <= 1'b0;
      p_valid  <= 1'b0;
      p_k      <= '0;
      p_cls    <= '0;
      acc      <= '0;
      best     <= '0;
      best_cls <= '0;
      label_r  <= '0;
    end else begin
      if (accept) begin
        feat_sr <= in_features;
        rd_addr <= '0;
        k_cnt   <= '0;
        c_cnt   <= '0;
        issuing <= 1'b1;
        p_valid <= 1'b0;
      end else if (issuing) begin
        p_valid <= 1'b1;
        p_k     <= k_cnt;
        p_cls   <= c_cnt;
        feat_q  <= feat_sr[LW-1:0];
        feat_sr <= {feat_sr[LW-1:0], feat_sr[FW-1:LW]};
        rd_addr <= rd_addr + 1'b1;
        if (k_cnt == K_LAST) begin
          k_cnt <= '0;
          if (c_cnt == C_LAST) issuing <= 1'b0;
          else                 c_cnt   <= c_cnt + 1'b1;
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end else begin
        p_valid <= 1'b0;
      end

      if (p_valid) begin
        acc <= acc_next;
        if (p_k == K_LAST) begin
          label_r[p_cls] <= ~acc_next[ACC_W-1];
          // Strict compare keeps the lower index on a tie.
          if ((p_cls == '0) || (acc_next > best)) begin
            best     <= acc_next;
            best_cls <= p_cls;
          end
        end
      end
    end
  end

  assign dout_label = label_r;
  assign dout_class = best_cls;

endmodule

// File: tb/tb_svm_linear_mc.sv
// Scoreboard bench for svm_linear_mc: a reference dot-product model predicts
// labels and argmax per vector; results are compared as the DUT emits them.
module tb_svm_linear_mc;

  localparam int NBITS   = 9;
  localparam int F_WIDTH = 214;
  localparam int N_CLS   = 4;
  localparam int NPAR    = 2;
  localparam int ACC_W   = 27;
  localparam int KPC     = F_WIDTH/NPAR;
  localparam int K       = N_CLS*KPC;
  localparam int AW      = 9;
  localparam int CW      = 2;
  localparam int LAT     = K + 1;

  typedef struct packed {
    logic [N_CLS-1:0] lbl;
    logic [CW-1:0]    cls;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     mem_we = 1'b1;
  logic [AW-1:0]            mem_write_addr = '0;
  logic [NPAR*NBITS-1:0]    mem_wdata = '0;
  logic                     bias_we = 1'b0;
  logic [CW-1:0]            bias_cls = '0;
  logic [ACC_W-1:0]         bias_data = '0;
  logic                     mem_write_done = 1'b0;
  logic                     cfg_reload = 1'b0;
  logic                     mem_write_ready;
  logic [NBITS*F_WIDTH-1:0] in_features = '0;
  logic                     fin_valid = 1'b0;
  logic                     fin_ready;
  logic [N_CLS-1:0]         dout_label;
  logic [CW-1:0]            dout_class;
  logic                     dout_valid;
  logic                     dout_ready = 1'b0;

  svm_linear_mc dut (
    .clk(clk), .rst(rst),
    .mem_we(mem_we), .mem_write_addr(mem_write_addr), .mem_wdata(mem_wdata),
    .bias_we(bias_we), .bias_cls(bias_cls), .bias_data(bias_data),
    .mem_write_done(mem_write_done), .cfg_reload(cfg_reload),
    .mem_write_ready(mem_write_ready),
    .in_features(in_features), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .dout_label(dout_label), .dout_class(dout_class),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  logic signed [NBITS-1:0] w_m [N_CLS][F_WIDTH];
  logic signed [ACC_W-1:0] b_m [N_CLS];
  logic signed [NBITS-1:0] f_m [F_WIDTH];
  exp_t sb [$];
  int checks = 0;
  int failures = 0;
  logic [N_CLS-1:0] last_lbl;
  logic [CW-1:0]    last_cls;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t   e;
    longint sc, best;
    e = '0;
    best = 0;
    for (int c = 0; c < N_CLS; c++) begin
      sc = longint'(b_m[c]);
      for (int f = 0; f < F_WIDTH; f++) sc += longint'(f_m[f]) * longint'(w_m[c][f]);
      e.lbl[c] = (sc >= 0);
      if (c == 0 || sc > best) begin
        best  = sc;
        e.cls = CW'(c);
      end
    end
    return e;
  endfunction

  task automatic set_weights_const(input int v);
    for (int c = 0; c < N_CLS; c++)
      for (int f = 0; f < F_WIDTH; f++) w_m[c][f] = NBITS'(v);
  endtask

  task automatic set_bias(input int b0, input int b1, input int b2, input int b3);
    b_m[0] = ACC_W'(b0); b_m[1] = ACC_W'(b1); b_m[2] = ACC_W'(b2); b_m[3] = ACC_W'(b3);
  endtask

  task automatic rand_feats();
    for (int f = 0; f < F_WIDTH; f++) f_m[f] = NBITS'($urandom);
  endtask

  // Full weight load; biases ride along on the first rows, done on the last row.
  task automatic load_all();
    for (int a = 0; a < K; a++) begin
      @(negedge clk);
      mem_we         = 1'b0;
      mem_write_addr = AW'(a);
      for (int j = 0; j < NPAR; j++)
        mem_wdata[j*NBITS +: NBITS] = w_m[a / KPC][(a % KPC)*NPAR + j];
      bias_we        = (a < N_CLS);
      bias_cls       = CW'(a % N_CLS);
      bias_data      = b_m[a % N_CLS];
      mem_write_done = (a == K-1);
    end
    @(negedge clk);
    mem_we = 1'b1; bias_we = 1'b0; mem_write_done = 1'b0;
    check("load_exit_ready", 64'(mem_write_ready), 64'd0);
  endtask

  task automatic load_bias_only();
    for (int c = 0; c < N_CLS; c++) begin
      @(negedge clk);
      bias_we = 1'b1; bias_cls = CW'(c); bias_data = b_m[c];
      mem_write_done = (c == N_CLS-1);
    end
    @(negedge clk);
    bias_we = 1'b0; mem_write_done = 1'b0;
  endtask

  task automatic go_load();
    @(negedge clk); cfg_reload = 1'b1;
    @(negedge clk); cfg_reload = 1'b0;
    check("reload_to_load", 64'(mem_write_ready), 64'd1);
  endtask

  task automatic drive_feats();
    for (int f = 0; f < F_WIDTH; f++) in_features[f*NBITS +: NBITS] = f_m[f];
  endtask

  task automatic send_vec(input int hold);
    int   n;
    exp_t e;
    drive_feats();
    @(negedge clk);
    check("fin_ready_idle", 64'(fin_ready), 64'd1);
    fin_valid = 1'b1;
    sb.push_back(predict());
    @(posedge clk); #1;
    fin_valid = 1'b0;
    for (int i = 0; i < NBITS*F_WIDTH; i++) in_features[i] = 1'($urandom);
    n = 0;
    while (n < 600 && !dout_valid) begin
      @(posedge clk); #1;
      n++;
      fin_valid = (n == 5 || n == 6);
    end
    fin_valid = 1'b0;
    check("latency", 64'(n), 64'(LAT));
    e = sb.pop_front();
    check("label", 64'(dout_label), 64'(e.lbl));
    check("class", 64'(dout_class), 64'(e.cls));
    last_lbl = dout_label;
    last_cls = dout_class;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(dout_valid), 64'd1);
      check("hold_label", 64'(dout_label), 64'(e.lbl));
      check("hold_class", 64'(dout_class), 64'(e.cls));
      check("hold_fin_ready", 64'(fin_ready), 64'd0);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check("consumed_valid", 64'(dout_valid), 64'd0);
    check("consumed_fin_ready", 64'(fin_ready), 64'd1);
  endtask

  initial begin
    logic seen_valid;
    #2;
    check("rst_mem_write_ready", 64'(mem_write_ready), 64'd1);
    check("rst_fin_ready", 64'(fin_ready), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_dout_label", 64'(dout_label), 64'd0);
    check("rst_dout_class", 64'(dout_class), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Zero weights: labels come straight from bias signs.
    set_weights_const(0);
    set_bias(5, -3, 0, -1);
    load_all();
    check("idle_fin_ready", 64'(fin_ready), 64'd1);
    rand_feats();
    send_vec(0);
    check("bias_only_label", 64'(last_lbl), 64'b0101);
    check("bias_only_class", 64'(last_cls), 64'd0);

    // Tie between classes 0 and 1 keeps the lower index.
    go_load();
    set_bias(7, 7, -1, -1);
    load_bias_only();
    rand_feats();
    send_vec(0);
    check("tie_label", 64'(last_lbl), 64'b0011);
    check("tie_class", 64'(last_cls), 64'd0);

    // Extreme magnitude on class 3, with output backpressure.
    go_load();
    set_weights_const(0);
    for (int f = 0; f < F_WIDTH; f++) w_m[3][f] = NBITS'(-256);
    set_bias(0, 0, 0, 0);
    load_all();
    for (int f = 0; f < F_WIDTH; f++) f_m[f] = NBITS'(-256);
    send_vec(10);
    check("max_label", 64'(last_lbl), 64'b1111);
    check("max_class", 64'(last_cls), 64'd3);

    // Random weights, biases and vectors.
    go_load();
    for (int c = 0; c < N_CLS; c++) begin
      for (int f = 0; f < F_WIDTH; f++) w_m[c][f] = NBITS'($urandom);
      b_m[c] = ACC_W'(int'($urandom_range(0, 2097152)) - 1048576);
    end
    load_all();
    for (int v = 0; v < 3; v++) begin
      rand_feats();
      send_vec(v);
    end

    // Reset 100 cycles into a computation; weights must survive.
    rand_feats();
    drive_feats();
    @(negedge clk);
    fin_valid = 1'b1;
    @(posedge clk); #1;
    fin_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_mem_write_ready", 64'(mem_write_ready), 64'd1);
    check("midrst_dout_valid", 64'(dout_valid), 64'd0);
    check("midrst_fin_ready", 64'(fin_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dout_valid) seen_valid = 1'b1;
    end
    mem_write_done = 1'b1;
    @(negedge clk);
    mem_write_done = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (dout_valid) seen_valid = 1'b1;
    end
    check("midrst_no_result", 64'(seen_valid), 64'd0);
    send_vec(0);

    // Ignored writes: during IDLE, and out-of-range addresses in LOAD.
    go_load();
    set_weights_const(0);
    set_bias(5, -3, 0, -1);
    load_all();
    @(negedge clk);
    mem_we = 1'b0; mem_write_addr = '0; mem_wdata = '1;
    bias_we = 1'b1; bias_cls = 2'd1; bias_data = ACC_W'(1000);
    @(negedge clk);
    mem_write_addr = AW'(200);
    @(negedge clk);
    mem_we = 1'b1; bias_we = 1'b0;
    go_load();
    for (int a = K; a < 512; a += 21) begin
      @(negedge clk);
      mem_we = 1'b0; mem_write_addr = AW'(a); mem_wdata = '1;
    end
    @(negedge clk);
    mem_write_addr = AW'(511);
    mem_write_done = 1'b1;
    @(negedge clk);
    mem_we = 1'b1; mem_write_done = 1'b0;
    rand_feats();
    send_vec(0);
    check("ignored_label", 64'(last_lbl), 64'b0101);
    check("ignored_class", 64'(last_cls), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
